// File: rtl/ro_meas_pkg.sv
// ============================================================================
//  Module   : ro_meas_pkg
//  Purpose  : Shared types and constants for the ring-oscillator frequency
//             counter (measurement FSM states, pipeline depths).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ro_meas_pkg;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      HOLD  = 2'd3
   } meas_state_t;

   // Flops in the osc_in metastability synchronizer
   localparam int SYNC_STAGES = 2;

   // Cycles spent in ARM so stale edges drain out of the synchronizer
   localparam int ARM_CYCLES  = 3;

endpackage

`default_nettype wire

// File: rtl/ro_sync_edge.sv
// ============================================================================
//  Module   : ro_sync_edge
//  Purpose  : Brings the free-running oscillator into the clk domain through
//             a multi-flop synchronizer and flags each rising edge with a
//             one-cycle pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ro_sync_edge
   import ro_meas_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic osc_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   edge_q;

   // Shift osc_in through the synchronizer, keep one delayed copy for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= '0;
         edge_q <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], osc_in};
         edge_q <= sync[SYNC_STAGES-1];
      end
   end

   assign edge_pulse = sync[SYNC_STAGES-1] & ~edge_q;

endmodule

`default_nettype wire

// File: rtl/ring_osc_freq_counter.sv
// ============================================================================
//  Module   : ring_osc_freq_counter
//  Purpose  : Counts ring-oscillator rising edges over a gate window of
//             2**GATE_LOG2 clk cycles, latches a saturating result and serves
//             it one byte at a time.
//  Config   : RO_FREQ_CONT_EN - when defined, HOLD lasts one cycle and the
//             sequencer re-arms on its own (continuous measuring).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ring_osc_freq_counter
   import ro_meas_pkg::*;
#(
   parameter int GATE_LOG2 = 10,
   parameter int CNT_W     = 16
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic       osc_in,
   input  logic [1:0] byte_sel,
   output logic [7:0] count_byte,
   output logic       busy,
   output logic       done,
   output logic       overflow
);

   localparam int               TMR_W     = GATE_LOG2 + 1;
   localparam int               NBYTES    = CNT_W / 8;
   localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'((1 << GATE_LOG2) - 1);
   localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   meas_state_t      state;
   meas_state_t      state_nxt;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_inc;
   logic [CNT_W-1:0] result;
   logic             start_q;
   logic             start_rise;
   logic             counter_sat;
   logic             edge_pulse;
   logic [31:0]      result_ext;

   ro_sync_edge u_sync_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .osc_in     (osc_in),
      .edge_pulse (edge_pulse)
   );

   // A request is a rising edge on start, only honoured while the tile is enabled
   assign start_rise  = start & ~start_q & ena;
   assign counter_sat = (counter == CNT_MAX);
   assign counter_inc = (edge_pulse && !counter_sat) ? counter + 1'b1 : counter;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs; losing ena aborts an active window
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start_rise) state_nxt = ARM;
         end
         ARM: begin
            busy = 1'b1;
            if (!ena)                  state_nxt = IDLE;
            else if (timer == ARM_LAST) state_nxt = COUNT;
         end
         COUNT: begin
            busy = 1'b1;
            if (!ena)                   state_nxt = IDLE;
            else if (timer == GATE_LAST) state_nxt = HOLD;
         end
         HOLD: begin
            done = 1'b1;
`ifdef RO_FREQ_CONT_EN
            if (ena) state_nxt = ARM;
`else
            if (start_rise) state_nxt = ARM;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gate timer, saturating edge counter, overflow flag and result latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q  <= 1'b0;
         timer    <= '0;
         counter  <= '0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE, HOLD: begin
               if (state_nxt == ARM) begin
                  timer    <= '0;
                  counter  <= '0;
                  overflow <= 1'b0;
               end
            end
            ARM: begin
               counter <= '0;
               if (!ena || timer == ARM_LAST) timer <= '0;
               else                            timer <= timer + 1'b1;
            end
            COUNT: begin
               if (!ena) begin
                  timer   <= '0;
                  counter <= '0;
               end else begin
                  timer   <= timer + 1'b1;
                  counter <= counter_inc;
                  if (edge_pulse && counter_sat) overflow <= 1'b1;
                  if (timer == GATE_LAST) begin
                     result <= counter_inc;
                     timer  <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Byte readout of the latched result, zero for bytes beyond CNT_W
   always_comb begin
      result_ext = 32'(result);
      count_byte = 8'h00;
      if ({1'b0, byte_sel} < 3'(NBYTES)) begin
         case (byte_sel)
            2'd0:    count_byte = result_ext[7:0];
            2'd1:    count_byte = result_ext[15:8];
            2'd2:    count_byte = result_ext[23:16];
            default: count_byte = result_ext[31:24];
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ring_osc_freq_counter.sv
// ============================================================================
//  Module   : tb_ring_osc_freq_counter
//  Purpose  : Self-checking bench for ring_osc_freq_counter. Two instances
//             (16-cycle gate / 16-bit result and 1024-cycle gate / 8-bit
//             result) are tracked by a window-level edge-counting model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ring_osc_freq_counter;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       ena      = 1'b0;
   logic       start_a  = 1'b0;
   logic       start_b  = 1'b0;
   logic       osc_in   = 1'b0;
   logic [1:0] byte_sel = 2'd0;
   logic [7:0] cb_a, cb_b;
   logic       busy_a, done_a, ovf_a;
   logic       busy_b, done_b, ovf_b;

   int n_cmp = 0;
   int n_bad = 0;
   int osc_mode = 0;   // 0 static low, 1 clk/2, 2 clk/4, 3 random

   always #5 clk = ~clk;

   ring_osc_freq_counter #(.GATE_LOG2(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_a), .osc_in(osc_in),
      .byte_sel(byte_sel), .count_byte(cb_a), .busy(busy_a), .done(done_a),
      .overflow(ovf_a)
   );

   ring_osc_freq_counter #(.GATE_LOG2(10), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_b), .osc_in(osc_in),
      .byte_sel(byte_sel), .count_byte(cb_b), .busy(busy_b), .done(done_b),
      .overflow(ovf_b)
   );

   function automatic int win_n(input int i);
      return (i == 0) ? 16 : 1024;
   endfunction
   function automatic int max_v(input int i);
      return (i == 0) ? 65535 : 255;
   endfunction
   function automatic int n_bytes(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Oscillator stimulus, changed away from both clock edges
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         #2;
         ph++;
         case (osc_mode)
            0:       osc_in = 1'b0;
            1:       osc_in = ~osc_in;
            2:       osc_in = ph[1];
            default: osc_in = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Behavioural model: a measurement is "start seen", then 3 settle cycles,
   // then a window of N cycles in which every synchronised rising edge of
   // osc_in (visible 3 clocks after it is sampled) adds one; the result is
   // min(edges, MAX) and overflow means edges exceeded MAX.
   // ---------------------------------------------------------------------
   bit hist [0:65535];
   int k = 0;
   int m_ph  [2];   // 0 idle, 1 measuring, 2 result held
   int m_bc  [2];   // clocks since the measurement was accepted
   int m_cnt [2];   // edges seen in the window so far
   int m_res [2];
   bit m_ovf [2];
   bit m_sp  [2];

   initial begin
      bit pulse, st, rise;
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0; m_bc[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_ovf[i] = 0; m_sp[i] = 0;
      end
      forever begin
         @(posedge clk);
         k++;
         hist[k] = rst_n ? osc_in : 1'b0;
         pulse = (k >= 3) ? (hist[k-2] && !hist[k-3]) : 1'b0;
         for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? start_a : start_b;
            if (!rst_n) begin
               m_ph[i] = 0; m_res[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_sp[i] = 0;
            end else begin
               rise    = st && !m_sp[i];
               m_sp[i] = st;
               case (m_ph[i])
                  0: if (ena && rise) begin
                        m_ph[i] = 1; m_bc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                     end
                  1: if (!ena) begin
                        m_ph[i] = 0;
                     end else begin
                        m_bc[i]++;
                        if (m_bc[i] >= 4) begin
                           if (pulse) m_cnt[i]++;
                           if (m_cnt[i] > max_v(i)) m_ovf[i] = 1;
                           if (m_bc[i] == 3 + win_n(i)) begin
                              m_res[i] = (m_cnt[i] > max_v(i)) ? max_v(i) : m_cnt[i];
                              m_ph[i]  = 2;
                           end
                        end
                     end
                  default: begin
`ifdef RO_FREQ_CONT_EN
                     if (ena) begin
`else
                     if (ena && rise) begin
`endif
                        m_ph[i] = 1; m_bc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                     end
                  end
               endcase
            end
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model
   initial begin
      int sel, eb;
      forever begin
         @(negedge clk);
         sel = int'(byte_sel);
         for (int i = 0; i < 2; i++) begin
            eb = (sel < n_bytes(i)) ? ((m_res[i] >> (8 * sel)) & 255) : 0;
            if (i == 0) begin
               check("a_busy", 32'(busy_a), 32'(m_ph[0] == 1));
               check("a_done", 32'(done_a), 32'(m_ph[0] == 2));
               check("a_ovf",  32'(ovf_a),  32'(m_ovf[0]));
               check("a_byte", 32'(cb_a),   32'(eb));
            end else begin
               check("b_busy", 32'(busy_b), 32'(m_ph[1] == 1));
               check("b_done", 32'(done_b), 32'(m_ph[1] == 2));
               check("b_ovf",  32'(ovf_b),  32'(m_ovf[1]));
               check("b_byte", 32'(cb_b),   32'(eb));
            end
         end
      end
   end

   // Request one measurement and count the clocks for which busy is high
   task automatic measure(input int i, output int bcyc);
      int t;
      @(negedge clk); #1;
      if (i == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk); #1;
      if (i == 0) start_a = 1'b0; else start_b = 1'b0;
      bcyc = 0;
      t    = 0;
      while (((i == 0) ? busy_a : busy_b) && t < 2000) begin
         bcyc++;
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("measure_timeout", 32'(t), 32'(0));
   endtask

   task automatic set_sel(input logic [1:0] v);
      #1 byte_sel = v;
      #1;
   endtask

   initial begin
      int bc, t;

      // Reset state
      repeat (4) @(negedge clk);
      check("rst_busy_a", 32'(busy_a), 0);
      check("rst_done_a", 32'(done_a), 0);
      check("rst_byte_a", 32'(cb_a),   0);
      check("rst_ovf_b",  32'(ovf_b),  0);
      #1 rst_n = 1'b1; ena = 1'b1;
      repeat (3) @(negedge clk);

      // clk/4 oscillator: 4 edges per 16-cycle window
      osc_mode = 2;
      repeat (4) @(negedge clk);
      measure(0, bc);
      check("a_busy_cycles", 32'(bc), 19);
      check("a_done_hold",   32'(done_a), 1);
      check("model_a_res4",  32'(m_res[0]), 4);
      set_sel(2'd0); check("a_byte0_q4", 32'(cb_a), 4);
      set_sel(2'd1); check("a_byte1_q4", 32'(cb_a), 0);
      check("a_ovf_q4", 32'(ovf_a), 0);
      set_sel(2'd0);

`ifdef RO_FREQ_CONT_EN
      // Continuous: done pulses every 20 cycles without new start requests
      for (int w = 0; w < 3; w++) begin
         t = 0;
         do begin @(negedge clk); t++; end while (!done_a && t < 100);
         check("cont_period", 32'(t), 20);
         check("cont_byte0",  32'(cb_a), 4);
      end
      // Saturation on the 8-bit instance, then a quiet window
      osc_mode = 1;
      measure(1, bc);
      check("b_busy_cycles", 32'(bc), 1027);
      check("b_byte_sat",    32'(cb_b), 255);
      check("b_ovf_sat",     32'(ovf_b), 1);
      osc_mode = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!done_b && t < 1200);
      check("b_quiet_done", 32'(done_b), 1);
      check("b_byte_quiet", 32'(cb_b), 0);
      check("b_ovf_quiet",  32'(ovf_b), 0);
`else
      // Static oscillator, then clk/2
      osc_mode = 0;
      repeat (4) @(negedge clk);
      measure(0, bc);
      check("a_byte0_static", 32'(cb_a), 0);
      check("a_ovf_static",   32'(ovf_a), 0);
      osc_mode = 1;
      repeat (4) @(negedge clk);
      measure(0, bc);
      check("a_byte0_half", 32'(cb_a), 8);
      check("model_a_res8", 32'(m_res[0]), 8);
      check("a_ovf_half",   32'(ovf_a), 0);

      // Abort mid-window: previous result stays readable
      osc_mode = 2;
      repeat (4) @(negedge clk);
      measure(0, bc);
      check("a_byte0_pre_abort", 32'(cb_a), 4);
      osc_mode = 1;
      @(negedge clk); #1 start_a = 1'b1;
      @(negedge clk); #1 start_a = 1'b0;
      repeat (6) @(negedge clk);
      #1 ena = 1'b0;
      @(negedge clk);
      check("abort_busy",  32'(busy_a), 0);
      check("abort_done",  32'(done_a), 0);
      check("abort_byte0", 32'(cb_a),   4);
      // start is ignored while disabled
      #1 start_a = 1'b1;
      repeat (3) @(negedge clk);
      check("dis_start_busy", 32'(busy_a), 0);
      #1 start_a = 1'b0; ena = 1'b1;
      @(negedge clk);

      // Saturation on the 8-bit instance, then a quiet window
      measure(1, bc);
      check("b_busy_cycles", 32'(bc), 1027);
      check("b_byte_sat",    32'(cb_b), 255);
      check("model_b_sat",   32'(m_res[1]), 255);
      check("b_ovf_sat",     32'(ovf_b), 1);
      set_sel(2'd1); check("b_byte1_oor", 32'(cb_b), 0);
      set_sel(2'd0);
      osc_mode = 0;
      repeat (4) @(negedge clk);
      measure(1, bc);
      check("b_byte_quiet", 32'(cb_b), 0);
      check("b_ovf_quiet",  32'(ovf_b), 0);
`endif

      // Reset in the middle of a window clears everything at once
      osc_mode = 2;
      @(negedge clk); #1 start_a = 1'b1;
      @(negedge clk); #1 start_a = 1'b0;
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy_a), 0);
      check("rst_mid_done", 32'(done_a), 0);
      check("rst_mid_ovf",  32'(ovf_a),  0);
      check("rst_mid_byte", 32'(cb_a),   0);
      check("rst_mid_bytb", 32'(cb_b),   0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", 32'(busy_a | done_a), 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         if (c % 150 == 0) osc_mode = $urandom_range(0, 3);
         ena      = ($urandom_range(0, 99) > 4);
         byte_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 11) == 0) start_a = ~start_a;
         if ($urandom_range(0, 63) == 0) start_b = ~start_b;
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d bad so far", n_bad);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
